// File: rtl/ahbl_slave_mem_if.sv
// AHB-Lite signal bundle between one master/fabric port and one ahbl_slave_mem responder.
// A transfer's data phase ends on the first rising edge where HREADYIN (global HREADY) is 1;
// the slave holds HREADYOUT low to stretch it, and a new address phase is taken only on such an edge.
interface ahbl_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite memory responder with wait states, a two-cycle ERROR response and an error region.
// Optional macro AHBL_SLV_RANDOM_WAIT_EN masks the wait count with a free-running 16-bit LFSR.
module ahbl_slave_mem #(
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_BASE    = 32'h0000_0F00,
  parameter bit          ERR_ENABLE  = 1'b1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  ahbl_slave_mem_if.slave        bus,
  output logic [1:0]             dbg_state
);
  localparam int         WORDS  = 2 ** (ADDR_BITS - 2);
  localparam logic [3:0] WAIT_W = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   dp_valid_q, dp_valid_d;
  logic [ADDR_BITS-1:0]   dp_addr_q, dp_addr_d;
  logic                   dp_write_q, dp_write_d;
  logic [1:0]             dp_size_q, dp_size_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [31:0]            hrdata_q, hrdata_d;
  logic [31:0]            mem_q [WORDS];

  logic [ADDR_BITS-1:0]   a_addr;
  logic                   capture, a_err, commit;
  logic [3:0]             wait_n, wr_be;
  logic [31:0]            rd_word;
  logic                   unused_sigs;

  assign a_addr      = bus.HADDR[ADDR_BITS-1:0];
  assign unused_sigs = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR};

`ifdef AHBL_SLV_RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign wait_n = lfsr_q[3:0] & WAIT_W;
  always_ff @(posedge HCLK) begin
    if (HRESET) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign wait_n = WAIT_W;
`endif

  // The slave's own HREADYOUT also gates capture so a stray HREADYIN cannot overlap a stalled phase.
  assign capture = bus.HSEL & bus.HREADYIN & bus.HTRANS[1] & hreadyout_q;
  assign a_err   = (bus.HSIZE > 3'd2)
                 | ((bus.HSIZE == 3'd1) & a_addr[0])
                 | ((bus.HSIZE == 3'd2) & (a_addr[1:0] != 2'b00))
                 | (ERR_ENABLE & (32'(a_addr) >= ERR_BASE));
  assign commit  = dp_valid_q & dp_write_q & hreadyout_q & ~HRESET;

  always_comb begin
    case (dp_size_q)
      2'd0:    wr_be = 4'b0001 << dp_addr_q[1:0];
      2'd1:    wr_be = dp_addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  // Forward write data committed on this edge so a back-to-back read sees it.
  always_comb begin
    rd_word = mem_q[a_addr[ADDR_BITS-1:2]];
    for (int i = 0; i < 4; i++) begin
      if (commit && (dp_addr_q[ADDR_BITS-1:2] == a_addr[ADDR_BITS-1:2]) && wr_be[i])
        rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_valid_d  = dp_valid_q;
    dp_addr_d   = dp_addr_q;
    dp_write_d  = dp_write_q;
    dp_size_d   = dp_size_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    if (capture) begin
      dp_addr_d  = a_addr;
      dp_write_d = bus.HWRITE;
      dp_size_d  = bus.HSIZE[1:0];
      if (!a_err && !bus.HWRITE) hrdata_d = rd_word;
    end
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hresp_d     = 1'b0;
        hreadyout_d = 1'b1;
        dp_valid_d  = 1'b0;
        if (capture) begin
          if (a_err) begin
            state_d     = ST_ERR1;
            hresp_d     = 1'b1;
            hreadyout_d = 1'b0;
          end else begin
            dp_valid_d = 1'b1;
            if (wait_n != 4'd0) begin
              state_d     = ST_WAIT;
              cnt_d       = wait_n - 4'd1;
              hreadyout_d = 1'b0;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hresp_d     = 1'b1;
        hreadyout_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      dp_valid_q  <= 1'b0;
      dp_addr_q   <= '0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_valid_q  <= dp_valid_d;
      dp_addr_q   <= dp_addr_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[dp_addr_q[ADDR_BITS-1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign dbg_state     = state_q;
endmodule
